// File: rtl/ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage_if
// Purpose  : Bundles the ID->EX operand inputs, the EX->ID forwarding
//            outputs, the EX/MEM stage outputs and the stall request of the
//            execute stage into a single interface.
// Ports    : aluop_i/alusel_i/reg1_i/reg2_i/wd_i/wreg_i   ID -> EX
//            ex_wreg_o/ex_wd_o/ex_wdata_o                 EX -> ID forwarding
//            mem_wreg_o/mem_wd_o/mem_wdata_o/
//            mem_whilo_o/mem_hi_o/mem_lo_o                EX/MEM register
//            stallreq_o                                   EX -> pipeline ctrl
// Modports : slave  - the execute stage itself
//            master - the driver of the operands (ID stage / testbench)
// Revision : 1.0 - initial release
// ============================================================================
interface ex_stage_if;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i;

  logic        ex_wreg_o;
  logic [4:0]  ex_wd_o;
  logic [31:0] ex_wdata_o;

  logic        mem_wreg_o;
  logic [4:0]  mem_wd_o;
  logic [31:0] mem_wdata_o;
  logic        mem_whilo_o;
  logic [31:0] mem_hi_o;
  logic [31:0] mem_lo_o;

  logic        stallreq_o;

  modport slave (
    input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
    output ex_wreg_o, ex_wd_o, ex_wdata_o,
    output mem_wreg_o, mem_wd_o, mem_wdata_o, mem_whilo_o, mem_hi_o, mem_lo_o,
    output stallreq_o
  );

  modport master (
    output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
    input  ex_wreg_o, ex_wd_o, ex_wdata_o,
    input  mem_wreg_o, mem_wd_o, mem_wdata_o, mem_whilo_o, mem_hi_o, mem_lo_o,
    input  stallreq_o
  );
endinterface
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage
// Purpose  : Execute stage. Computes logic and shift results combinationally
//            (forwarded back to ID), runs a 32-step restoring divider for
//            DIV/DIVU while stalling the front end, and registers the result
//            into the EX/MEM pipeline register.
// Ports    : clk  - sole clock, rising edge
//            rst  - synchronous, active-low reset
//            bus  - ex_stage_if.slave (operands, forwarding, EX/MEM, stall)
// Params   : DATA_W - datapath width (32 only)
// Revision : 1.0 - initial release
// ============================================================================
module ex_stage #(
  parameter int DATA_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  ex_stage_if.slave   bus
);

  localparam logic [7:0] c_OP_AND  = 8'h24;
  localparam logic [7:0] c_OP_OR   = 8'h25;
  localparam logic [7:0] c_OP_XOR  = 8'h26;
  localparam logic [7:0] c_OP_NOR  = 8'h27;
  localparam logic [7:0] c_OP_SLL  = 8'h7C;
  localparam logic [7:0] c_OP_SRL  = 8'h02;
  localparam logic [7:0] c_OP_SRA  = 8'h03;
  localparam logic [7:0] c_OP_DIV  = 8'h1A;
  localparam logic [7:0] c_OP_DIVU = 8'h1B;

  localparam logic [2:0] c_SEL_LOGIC = 3'b001;
  localparam logic [2:0] c_SEL_SHIFT = 3'b010;

  localparam logic [4:0] c_LAST_STEP = 5'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [4:0]          r_cnt;
  logic [DATA_W-1:0]   r_dvd;     // dividend bits shift out, quotient bits shift in
  logic [DATA_W-1:0]   r_dvs;
  logic [DATA_W-1:0]   r_rem;
  logic                r_neg_q;
  logic                r_neg_r;

  logic [DATA_W-1:0]   w_logic;
  logic [DATA_W-1:0]   w_shift;
  logic [DATA_W-1:0]   w_result;
  logic                w_is_div;
  logic                w_signed;
  logic                w_stall;
  logic [DATA_W:0]     w_trial;
  logic                w_qbit;
  logic [DATA_W-1:0]   w_sub;
  logic [DATA_W-1:0]   w_quot;
  logic [DATA_W-1:0]   w_remf;

  // ---------------- combinational ALU ----------------
  always_comb begin
    w_logic = '0;
    case (bus.aluop_i)
      c_OP_AND: w_logic = bus.reg1_i & bus.reg2_i;
      c_OP_OR:  w_logic = bus.reg1_i | bus.reg2_i;
      c_OP_XOR: w_logic = bus.reg1_i ^ bus.reg2_i;
      c_OP_NOR: w_logic = ~(bus.reg1_i | bus.reg2_i);
      default:  w_logic = '0;
    endcase
  end

  always_comb begin
    w_shift = '0;
    case (bus.aluop_i)
      c_OP_SLL: w_shift = bus.reg2_i << bus.reg1_i[4:0];
      c_OP_SRL: w_shift = bus.reg2_i >> bus.reg1_i[4:0];
      c_OP_SRA: w_shift = DATA_W'($signed(bus.reg2_i) >>> bus.reg1_i[4:0]);
      default:  w_shift = '0;
    endcase
  end

  always_comb begin
    w_result = '0;
    case (bus.alusel_i)
      c_SEL_LOGIC: w_result = w_logic;
      c_SEL_SHIFT: w_result = w_shift;
      default:     w_result = '0;
    endcase
  end

  // Forwarding path is held at zero during reset.
  assign bus.ex_wreg_o  = rst ? bus.wreg_i : 1'b0;
  assign bus.ex_wd_o    = rst ? bus.wd_i   : 5'd0;
  assign bus.ex_wdata_o = rst ? w_result   : '0;

  // ---------------- divider FSM ----------------
  assign w_is_div = (bus.aluop_i == c_OP_DIV) || (bus.aluop_i == c_OP_DIVU);
  assign w_signed = (bus.aluop_i == c_OP_DIV);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_is_div) begin
          w_stall = 1'b1;
          w_next  = (bus.reg2_i == '0) ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        w_stall = 1'b1;
        if (r_cnt == c_LAST_STEP) begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign bus.stallreq_o = rst & w_stall;

  // One restoring step: bring down the next dividend bit and subtract the
  // divisor if it fits. The trial value can reach 2*divisor, hence 33 bits;
  // the subtraction result always fits in DATA_W bits.
  assign w_trial = {r_rem, r_dvd[DATA_W-1]};
  assign w_qbit  = (w_trial >= {1'b0, r_dvs});
  assign w_sub   = w_trial[DATA_W-1:0] - r_dvs;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt   <= 5'd0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_rem   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_is_div) begin
            r_cnt <= 5'd0;
            r_rem <= '0;
            if (bus.reg2_i == '0) begin
              r_dvd   <= '0;
              r_dvs   <= '0;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
            end else begin
              r_dvd   <= (w_signed && bus.reg1_i[DATA_W-1]) ? -bus.reg1_i : bus.reg1_i;
              r_dvs   <= (w_signed && bus.reg2_i[DATA_W-1]) ? -bus.reg2_i : bus.reg2_i;
              r_neg_q <= w_signed & (bus.reg1_i[DATA_W-1] ^ bus.reg2_i[DATA_W-1]);
              r_neg_r <= w_signed & bus.reg1_i[DATA_W-1];
            end
          end
        end
        S_BUSY: begin
          r_rem <= w_qbit ? w_sub : w_trial[DATA_W-1:0];
          r_dvd <= {r_dvd[DATA_W-2:0], w_qbit};
          r_cnt <= r_cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign w_quot = r_neg_q ? -r_dvd : r_dvd;
  assign w_remf = r_neg_r ? -r_rem : r_rem;

  // ---------------- EX/MEM register ----------------
  always_ff @(posedge clk) begin
    if (!rst || w_stall) begin
      // reset and stall both insert a bubble
      bus.mem_wreg_o  <= 1'b0;
      bus.mem_wd_o    <= 5'd0;
      bus.mem_wdata_o <= '0;
      bus.mem_whilo_o <= 1'b0;
      bus.mem_hi_o    <= '0;
      bus.mem_lo_o    <= '0;
    end else begin
      bus.mem_wreg_o  <= bus.ex_wreg_o;
      bus.mem_wd_o    <= bus.ex_wd_o;
      bus.mem_wdata_o <= bus.ex_wdata_o;
      bus.mem_whilo_o <= (r_state == S_DONE);
      bus.mem_hi_o    <= (r_state == S_DONE) ? w_remf : '0;
      bus.mem_lo_o    <= (r_state == S_DONE) ? w_quot : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_stage
// Purpose  : Self-checking bench for ex_stage. Directed steps in one initial
//            block; expected EX/MEM contents are queued when stimulus is
//            applied and popped after the following clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_stage;

  localparam logic [7:0] c_NOP  = 8'h00;
  localparam logic [7:0] c_AND  = 8'h24;
  localparam logic [7:0] c_OR   = 8'h25;
  localparam logic [7:0] c_XOR  = 8'h26;
  localparam logic [7:0] c_NOR  = 8'h27;
  localparam logic [7:0] c_SLL  = 8'h7C;
  localparam logic [7:0] c_SRL  = 8'h02;
  localparam logic [7:0] c_SRA  = 8'h03;
  localparam logic [7:0] c_DIV  = 8'h1A;
  localparam logic [7:0] c_DIVU = 8'h1B;
  localparam logic [2:0] c_SNOP = 3'b000;
  localparam logic [2:0] c_SLOG = 3'b001;
  localparam logic [2:0] c_SSH  = 3'b010;

  typedef struct {
    logic        wreg;
    logic [4:0]  wd;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
  } mem_t;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;
  mem_t sb_q[$];

  ex_stage_if bus ();

  ex_stage #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [7:0] op, input logic [2:0] sel,
                        input logic [31:0] r1, input logic [31:0] r2,
                        input logic [4:0] wd, input logic wreg);
    bus.aluop_i  = op;
    bus.alusel_i = sel;
    bus.reg1_i   = r1;
    bus.reg2_i   = r2;
    bus.wd_i     = wd;
    bus.wreg_i   = wreg;
    #1;
  endtask

  task automatic push(input logic wreg, input logic [4:0] wd, input logic [31:0] wdata,
                      input logic whilo, input logic [31:0] hi, input logic [31:0] lo);
    mem_t e;
    e.wreg = wreg; e.wd = wd; e.wdata = wdata;
    e.whilo = whilo; e.hi = hi; e.lo = lo;
    sb_q.push_back(e);
  endtask

  // Advance one edge, then compare the registered outputs with the queue head.
  task automatic step_clk(input string tag);
    mem_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk({tag, ".mem_wreg"},  {31'd0, bus.mem_wreg_o},  {31'd0, e.wreg});
      chk({tag, ".mem_wd"},    {27'd0, bus.mem_wd_o},    {27'd0, e.wd});
      chk({tag, ".mem_wdata"}, bus.mem_wdata_o,          e.wdata);
      chk({tag, ".mem_whilo"}, {31'd0, bus.mem_whilo_o}, {31'd0, e.whilo});
      chk({tag, ".mem_hi"},    bus.mem_hi_o,             e.hi);
      chk({tag, ".mem_lo"},    bus.mem_lo_o,             e.lo);
    end
  endtask

  task automatic alu_op(input string tag, input logic [7:0] op, input logic [2:0] sel,
                        input logic [31:0] r1, input logic [31:0] r2,
                        input logic [4:0] wd, input logic [31:0] exp);
    set_in(op, sel, r1, r2, wd, 1'b1);
    chk({tag, ".ex_wdata"}, bus.ex_wdata_o, exp);
    chk({tag, ".ex_wd"},    {27'd0, bus.ex_wd_o}, {27'd0, wd});
    chk({tag, ".ex_wreg"},  {31'd0, bus.ex_wreg_o}, 32'd1);
    chk({tag, ".stall"},    {31'd0, bus.stallreq_o}, 32'd0);
    push(1'b1, wd, exp, 1'b0, 32'd0, 32'd0);
    step_clk(tag);
  endtask

  task automatic div_op(input string tag, input logic [7:0] op,
                        input logic [31:0] r1, input logic [31:0] r2, input logic [4:0] wd,
                        input logic [31:0] exp_lo, input logic [31:0] exp_hi, input int n_stall);
    set_in(op, c_SNOP, r1, r2, wd, 1'b0);
    for (int i = 0; i < n_stall; i++) begin
      chk({tag, ".stall_hi"}, {31'd0, bus.stallreq_o}, 32'd1);
      push(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);
      step_clk({tag, ".bubble"});
    end
    chk({tag, ".stall_lo"}, {31'd0, bus.stallreq_o}, 32'd0);
    push(1'b0, wd, 32'd0, 1'b1, exp_hi, exp_lo);
    step_clk({tag, ".done"});
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;

    // Reset with live OR operands: forwarding and stall held at zero.
    rst = 1'b0;
    set_in(c_OR, c_SLOG, 32'hF0F0_0000, 32'h0000_FFFF, 5'd5, 1'b1);
    push(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    step_clk("rst0");
    chk("rst.ex_wdata", bus.ex_wdata_o, 32'd0);
    chk("rst.ex_wreg",  {31'd0, bus.ex_wreg_o}, 32'd0);
    chk("rst.stall",    {31'd0, bus.stallreq_o}, 32'd0);
    push(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    step_clk("rst1");
    rst = 1'b1;

    // Logic and shift operations.
    alu_op("or",    c_OR,  c_SLOG, 32'hF0F0_0000, 32'h0000_FFFF, 5'd5, 32'hF0F0_FFFF);
    alu_op("and",   c_AND, c_SLOG, 32'hF0F0_FF00, 32'h0F0F_FFFF, 5'd6, 32'h0000_FF00);
    alu_op("xor",   c_XOR, c_SLOG, 32'hF0F0_FF00, 32'h0F0F_FFFF, 5'd7, 32'hFFFF_00FF);
    alu_op("nor",   c_NOR, c_SLOG, 32'hF0F0_0000, 32'h0000_FFFF, 5'd8, 32'h0F0F_0000);
    alu_op("sra",   c_SRA, c_SSH,  32'd4,         32'h8000_0010, 5'd9, 32'hF800_0001);
    alu_op("srl",   c_SRL, c_SSH,  32'd4,         32'h8000_0010, 5'd10, 32'h0800_0001);
    alu_op("sll",   c_SLL, c_SSH,  32'h21,        32'h0000_0010, 5'd11, 32'h0000_0020);
    alu_op("unk",   8'h55, c_SLOG, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 32'd0);
    alu_op("selnop", c_OR, c_SNOP, 32'hFFFF_FFFF, 32'h1234_5678, 5'd0, 32'd0);

    // Divider.
    div_op("div_m7_2",  c_DIV,  32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
    div_op("div_7_m2",  c_DIV,  32'd7, 32'hFFFF_FFFE, 5'd4, 32'hFFFF_FFFD, 32'd1, 33);
    div_op("div_100_m7", c_DIV, 32'd100, 32'hFFFF_FFF9, 5'd4, 32'hFFFF_FFF2, 32'd2, 33);
    div_op("div_min_m1", c_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 32'h8000_0000, 32'd0, 33);
    div_op("divu_big", c_DIVU, 32'hFFFF_FFFF, 32'd16, 5'd2, 32'h0FFF_FFFF, 32'd15, 33);
    div_op("divu_z",   c_DIVU, 32'hFFFF_FFFF, 32'd0, 5'd2, 32'd0, 32'd0, 1);

    // Reset while BUSY at counter 10: no partial result, FSM back in IDLE.
    set_in(c_DIVU, c_SNOP, 32'd100, 32'd7, 5'd1, 1'b0);
    for (int i = 0; i < 11; i++) begin
      chk("rstmid.stall_hi", {31'd0, bus.stallreq_o}, 32'd1);
      push(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);
      step_clk("rstmid.bubble");
    end
    rst = 1'b0;
    set_in(c_NOP, c_SNOP, 32'd0, 32'd0, 5'd0, 1'b0);
    chk("rstmid.stall_rst", {31'd0, bus.stallreq_o}, 32'd0);
    push(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    step_clk("rstmid.rst");
    rst = 1'b1;
    #1;
    chk("rstmid.idle_stall", {31'd0, bus.stallreq_o}, 32'd0);
    push(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    step_clk("rstmid.idle");
    div_op("divu_100_7", c_DIVU, 32'd100, 32'd7, 5'd1, 32'd14, 32'd2, 33);

    // Divide followed immediately by OR: no bubble after DONE.
    div_op("divu_9_3", c_DIVU, 32'd9, 32'd3, 5'd2, 32'd3, 32'd0, 33);
    alu_op("or_after_div", c_OR, c_SLOG, 32'hF0F0_0000, 32'h0000_FFFF, 5'd5, 32'hF0F0_FFFF);

    chk("sb_drained", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
